// File: rtl/reg_access_master.sv
// rtl/reg_access_master.sv - single-register read/write initiator for reg_control/reg_file
// Sequences selects, lane gates, bus drive and write strobes for one request at a time.
module reg_access_master #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_reg,
  input  logic [1:0]  req_hilo,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  ctl_reg_gp_sel,
  output logic [1:0]  ctl_reg_gp_hilo,
  output logic        ctl_reg_gp_we,
  output logic        ctl_reg_use_sp,
  output logic [1:0]  ctl_reg_sys_hilo,
  output logic        ctl_reg_sys_we_hi,
  output logic        ctl_reg_sys_we_lo,
  output logic        ctl_reg_sel_wz,
  output logic        ctl_reg_sel_pc,
  output logic        ctl_reg_sel_ir,
  output logic        ctl_reg_in_hi,
  output logic        ctl_reg_in_lo,
  output logic        ctl_reg_out_hi,
  output logic        ctl_reg_out_lo,
  output logic        ctl_sw_4d,
  output logic        ctl_sw_4u,
  output logic [15:0] db_ds_out,
  output logic        db_ds_oe,
  input  logic [15:0] db_ds_in
);

  typedef enum logic [2:0] {IDLE, CHECK, SETUP, ACT, DONE} state_t;

  typedef struct packed {
    logic [1:0]  gp_sel;
    logic [1:0]  gp_hilo;
    logic        gp_we;
    logic        use_sp;
    logic [1:0]  sys_hilo;
    logic        sys_we_hi;
    logic        sys_we_lo;
    logic        sel_wz;
    logic        sel_pc;
    logic        sel_ir;
    logic        in_hi;
    logic        in_lo;
    logic        out_hi;
    logic        out_lo;
    logic        sw_4d;
    logic        sw_4u;
    logic        oe;
    logic [15:0] out;
  } ctl_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [3:0]  reg_q, reg_d;
  logic [1:0]  hilo_q, hilo_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  ctl_t        ctl_q, ctl_d;

  logic        illegal;
  logic        is_sys;
  logic        active;
  logic [15:0] lane_mask;

  assign illegal   = reg_q[3] || (hilo_q == 2'b00);
  assign is_sys    = reg_q[2] && (reg_q[1:0] != 2'b00);
  assign lane_mask = {{8{hilo_q[1]}}, {8{hilo_q[0]}}};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    reg_d       = reg_q;
    hilo_d      = hilo_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          reg_d   = req_reg;
          hilo_d  = req_hilo;
          wdata_d = req_wdata;
          rdata_d = 16'h0000;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (illegal) begin
          state_d = DONE;
        end else begin
          cnt_d   = 4'(SETTLE_CYCLES);
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACT;
      end
      ACT: begin
        if (!wr_q) rdata_d = db_ds_in & lane_mask;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe and select is a flop output.
  always_comb begin
    ctl_d       = '0;
    active      = (state_d == SETUP) || (state_d == ACT);
    rsp_valid_d = (state_d == DONE);
    rsp_err_d   = (state_d == DONE) && illegal;
    if (active) begin
      if (is_sys) begin
        ctl_d.sys_hilo = hilo_q;
        ctl_d.sel_wz   = (reg_q[1:0] == 2'b01);
        ctl_d.sel_pc   = (reg_q[1:0] == 2'b10);
        ctl_d.sel_ir   = (reg_q[1:0] == 2'b11);
      end else begin
        ctl_d.gp_sel  = reg_q[2] ? 2'b11 : reg_q[1:0];
        ctl_d.use_sp  = reg_q[2];
        ctl_d.gp_hilo = hilo_q;
      end
      if (wr_q) begin
        ctl_d.in_hi = hilo_q[1];
        ctl_d.in_lo = hilo_q[0];
        ctl_d.oe    = 1'b1;
        ctl_d.out   = wdata_q & lane_mask;
        ctl_d.sw_4d = is_sys;
        if (state_d == ACT) begin
          ctl_d.gp_we     = !is_sys;
          ctl_d.sys_we_hi = is_sys && hilo_q[1];
          ctl_d.sys_we_lo = is_sys && hilo_q[0];
        end
      end else begin
        ctl_d.out_hi = hilo_q[1];
        ctl_d.out_lo = hilo_q[0];
        ctl_d.sw_4u  = is_sys && reg_q[1];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      reg_q       <= 4'd0;
      hilo_q      <= 2'b00;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ctl_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      reg_q       <= reg_d;
      hilo_q      <= hilo_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      ctl_q       <= ctl_d;
    end
  end

  assign req_ready         = (state_q == IDLE);
  assign rsp_valid         = rsp_valid_q;
  assign rsp_err           = rsp_err_q;
  assign rsp_rdata         = rdata_q;
  assign ctl_reg_gp_sel    = ctl_q.gp_sel;
  assign ctl_reg_gp_hilo   = ctl_q.gp_hilo;
  assign ctl_reg_gp_we     = ctl_q.gp_we;
  assign ctl_reg_use_sp    = ctl_q.use_sp;
  assign ctl_reg_sys_hilo  = ctl_q.sys_hilo;
  assign ctl_reg_sys_we_hi = ctl_q.sys_we_hi;
  assign ctl_reg_sys_we_lo = ctl_q.sys_we_lo;
  assign ctl_reg_sel_wz    = ctl_q.sel_wz;
  assign ctl_reg_sel_pc    = ctl_q.sel_pc;
  assign ctl_reg_sel_ir    = ctl_q.sel_ir;
  assign ctl_reg_in_hi     = ctl_q.in_hi;
  assign ctl_reg_in_lo     = ctl_q.in_lo;
  assign ctl_reg_out_hi    = ctl_q.out_hi;
  assign ctl_reg_out_lo    = ctl_q.out_lo;
  assign ctl_sw_4d         = ctl_q.sw_4d;
  assign ctl_sw_4u         = ctl_q.sw_4u;
  assign db_ds_out         = ctl_q.out;
  assign db_ds_oe          = ctl_q.oe;

endmodule

// File: tb/tb_reg_access_master.sv
// tb/tb_reg_access_master.sv - directed bench for reg_access_master
// Two instances (SETTLE_CYCLES 1 and 4) share a small register-file model on the data-side bus.
module tb_reg_access_master;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0, use4 = 1'b0;
  logic [3:0]  req_reg = 4'd0;
  logic [1:0]  req_hilo = 2'b00;
  logic [15:0] req_wdata = 16'h0000;
  logic [15:0] db_ds_in;

  logic        a_ready, a_rv, a_err, b_ready, b_rv, b_err;
  logic [15:0] a_rdata, b_rdata, a_out, b_out;
  logic [1:0]  a_gp_sel, a_gp_hilo, a_sys_hilo, b_gp_sel, b_gp_hilo, b_sys_hilo;
  logic        a_gp_we, a_use_sp, a_we_hi, a_we_lo, a_wz, a_pc, a_ir;
  logic        a_in_hi, a_in_lo, a_out_hi, a_out_lo, a_sw4d, a_sw4u, a_oe;
  logic        b_gp_we, b_use_sp, b_we_hi, b_we_lo, b_wz, b_pc, b_ir;
  logic        b_in_hi, b_in_lo, b_out_hi, b_out_lo, b_sw4d, b_sw4u, b_oe;

  reg_access_master #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid && !use4), .req_ready(a_ready),
    .req_write(req_write), .req_reg(req_reg), .req_hilo(req_hilo), .req_wdata(req_wdata),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err),
    .ctl_reg_gp_sel(a_gp_sel), .ctl_reg_gp_hilo(a_gp_hilo), .ctl_reg_gp_we(a_gp_we),
    .ctl_reg_use_sp(a_use_sp), .ctl_reg_sys_hilo(a_sys_hilo), .ctl_reg_sys_we_hi(a_we_hi),
    .ctl_reg_sys_we_lo(a_we_lo), .ctl_reg_sel_wz(a_wz), .ctl_reg_sel_pc(a_pc), .ctl_reg_sel_ir(a_ir),
    .ctl_reg_in_hi(a_in_hi), .ctl_reg_in_lo(a_in_lo), .ctl_reg_out_hi(a_out_hi), .ctl_reg_out_lo(a_out_lo),
    .ctl_sw_4d(a_sw4d), .ctl_sw_4u(a_sw4u), .db_ds_out(a_out), .db_ds_oe(a_oe), .db_ds_in(db_ds_in)
  );

  reg_access_master #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .nreset(nreset), .req_valid(req_valid && use4), .req_ready(b_ready),
    .req_write(req_write), .req_reg(req_reg), .req_hilo(req_hilo), .req_wdata(req_wdata),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err),
    .ctl_reg_gp_sel(b_gp_sel), .ctl_reg_gp_hilo(b_gp_hilo), .ctl_reg_gp_we(b_gp_we),
    .ctl_reg_use_sp(b_use_sp), .ctl_reg_sys_hilo(b_sys_hilo), .ctl_reg_sys_we_hi(b_we_hi),
    .ctl_reg_sys_we_lo(b_we_lo), .ctl_reg_sel_wz(b_wz), .ctl_reg_sel_pc(b_pc), .ctl_reg_sel_ir(b_ir),
    .ctl_reg_in_hi(b_in_hi), .ctl_reg_in_lo(b_in_lo), .ctl_reg_out_hi(b_out_hi), .ctl_reg_out_lo(b_out_lo),
    .ctl_sw_4d(b_sw4d), .ctl_sw_4u(b_sw4u), .db_ds_out(b_out), .db_ds_oe(b_oe), .db_ds_in(db_ds_in)
  );

  logic        m_ready, m_rv, m_err;
  logic [15:0] m_rdata, m_out;
  logic [1:0]  m_gp_sel, m_gp_hilo, m_sys_hilo;
  logic        m_gp_we, m_use_sp, m_we_hi, m_we_lo, m_wz, m_pc, m_ir;
  logic        m_in_hi, m_in_lo, m_out_hi, m_out_lo, m_sw4d, m_sw4u, m_oe;
  logic [36:0] a_bus, b_bus, m_bus;
  logic [32:0] m_sel;

  assign a_bus = {a_gp_sel, a_gp_hilo, a_gp_we, a_use_sp, a_sys_hilo, a_we_hi, a_we_lo, a_wz, a_pc, a_ir,
                  a_in_hi, a_in_lo, a_out_hi, a_out_lo, a_sw4d, a_sw4u, a_oe, a_out};
  assign b_bus = {b_gp_sel, b_gp_hilo, b_gp_we, b_use_sp, b_sys_hilo, b_we_hi, b_we_lo, b_wz, b_pc, b_ir,
                  b_in_hi, b_in_lo, b_out_hi, b_out_lo, b_sw4d, b_sw4u, b_oe, b_out};
  assign m_bus = use4 ? b_bus : a_bus;
  assign {m_gp_sel, m_gp_hilo, m_gp_we, m_use_sp, m_sys_hilo, m_we_hi, m_we_lo, m_wz, m_pc, m_ir,
          m_in_hi, m_in_lo, m_out_hi, m_out_lo, m_sw4d, m_sw4u, m_oe, m_out} = m_bus;
  assign m_ready = use4 ? b_ready : a_ready;
  assign m_rv    = use4 ? b_rv    : a_rv;
  assign m_err   = use4 ? b_err   : a_err;
  assign m_rdata = use4 ? b_rdata : a_rdata;
  assign m_sel   = {m_gp_sel, m_gp_hilo, m_use_sp, m_sys_hilo, m_wz, m_pc, m_ir, m_in_hi, m_in_lo,
                    m_out_hi, m_out_lo, m_sw4d, m_sw4u, m_oe, m_out};

  // Register file model: AF,BC,DE,HL,SP then WZ,PC,IR; undriven read lanes float as EE.
  logic [15:0] gp_regs [5];
  logic [15:0] sys_regs [3];
  logic [15:0] rd_val;
  int          gi, si;

  always_comb begin
    gi = m_use_sp ? 4 : int'(m_gp_sel);
    si = m_wz ? 0 : (m_pc ? 1 : 2);
    rd_val = (m_wz || m_pc || m_ir) ? sys_regs[si] : gp_regs[gi];
    db_ds_in = {m_out_hi ? rd_val[15:8] : 8'hEE, m_out_lo ? rd_val[7:0] : 8'hEE};
  end

  always @(posedge clk) begin
    if (m_gp_we && m_gp_hilo[1]) gp_regs[gi][15:8] <= m_out[15:8];
    if (m_gp_we && m_gp_hilo[0]) gp_regs[gi][7:0]  <= m_out[7:0];
    if (m_we_hi) sys_regs[si][15:8] <= m_out[15:8];
    if (m_we_lo) sys_regs[si][7:0]  <= m_out[7:0];
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xact(input bit b4, input bit wr, input logic [3:0] r, input logic [1:0] hl,
                      input logic [15:0] wd, input logic [15:0] exp_rd, input bit exp_err,
                      input int exp_lat, input string tag,
                      output int we_cyc, output bit sw4d, output bit sw4u, output bit any_ctl,
                      output int stable);
    int n, run;
    logic [32:0] prev;
    n = 0; run = 0; we_cyc = 0; sw4d = 0; sw4u = 0; any_ctl = 0; stable = 0;
    @(negedge clk);
    use4 = b4;
    while (!m_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = wr; req_reg = r; req_hilo = hl; req_wdata = wd;
    prev = m_sel;
    n = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      n++;
      if (m_sel == prev) run++; else run = 1;
      prev = m_sel;
      if (m_gp_we || m_we_hi || m_we_lo) begin
        we_cyc++;
        stable = run;
      end
      sw4d |= m_sw4d;
      sw4u |= m_sw4u;
      any_ctl |= (|m_bus);
    end while (!m_rv && n < 40);
    if (!m_rv) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " latency"}, n, exp_lat);
      check({tag, " err"}, m_err, exp_err);
      check({tag, " rdata"}, m_rdata, exp_rd);
    end
  endtask

  initial begin
    int we_cyc, stable;
    bit sw4d, sw4u, any_ctl, rv_seen;
    logic [15:0] v;

    repeat (2) @(negedge clk);
    check("reset ready", a_ready, 1);
    check("reset rsp_valid", a_rv, 0);
    check("reset ctl/bus", |a_bus, 0);
    check("reset rdata", a_rdata, 0);
    nreset = 1'b1;

    // Abort a PC write in the middle of SETUP.
    @(negedge clk);
    use4 = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_reg = 4'd6; req_hilo = 2'b11; req_wdata = 16'h8242;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort sel_pc before reset", m_pc, 1);
    check("abort oe before reset", m_oe, 1);
    nreset = 1'b0;
    #1;
    check("abort ctl/bus dropped", |m_bus, 0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("abort ready", m_ready, 1);
    rv_seen = 0;
    repeat (8) begin
      @(negedge clk);
      rv_seen |= m_rv;
    end
    check("abort no response", rv_seen, 0);

    for (int i = 0; i < 4; i++) begin
      v = {8'hAA + 8'(i), 8'h55 + 8'(i)};
      xact(0, 1, 4'(i), 2'b11, v, 16'h0000, 0, 4, $sformatf("gp wr %0d", i),
           we_cyc, sw4d, sw4u, any_ctl, stable);
      check($sformatf("gp wr %0d we cycles", i), we_cyc, 1);
      check($sformatf("gp wr %0d sw4d", i), sw4d, 0);
    end
    for (int i = 0; i < 4; i++) begin
      v = {8'hAA + 8'(i), 8'h55 + 8'(i)};
      xact(0, 0, 4'(i), 2'b11, 16'h0000, v, 0, 4, $sformatf("gp rd %0d", i),
           we_cyc, sw4d, sw4u, any_ctl, stable);
      check($sformatf("gp rd %0d no strobe", i), we_cyc, 0);
      check($sformatf("gp rd %0d sw4u", i), sw4u, 0);
    end

    for (int i = 0; i < 3; i++) begin
      v = {8'h81 + 8'(i), 8'h41 + 8'(i)};
      xact(0, 1, 4'(5 + i), 2'b11, v, 16'h0000, 0, 4, $sformatf("sys wr %0d", 5 + i),
           we_cyc, sw4d, sw4u, any_ctl, stable);
      check($sformatf("sys wr %0d we cycles", 5 + i), we_cyc, 1);
      check($sformatf("sys wr %0d sw4d", 5 + i), sw4d, 1);
      check($sformatf("sys wr %0d sw4u", 5 + i), sw4u, 0);
    end
    for (int i = 0; i < 3; i++) begin
      v = {8'h81 + 8'(i), 8'h41 + 8'(i)};
      xact(0, 0, 4'(5 + i), 2'b11, 16'h0000, v, 0, 4, $sformatf("sys rd %0d", 5 + i),
           we_cyc, sw4d, sw4u, any_ctl, stable);
      check($sformatf("sys rd %0d sw4u", 5 + i), sw4u, (i != 0));
      check($sformatf("sys rd %0d sw4d", 5 + i), sw4d, 0);
    end

    xact(0, 1, 4'd3, 2'b11, 16'hFFFF, 16'h0000, 0, 4, "hl wr ffff", we_cyc, sw4d, sw4u, any_ctl, stable);
    xact(0, 1, 4'd3, 2'b01, 16'h0012, 16'h0000, 0, 4, "hl wr lo 12", we_cyc, sw4d, sw4u, any_ctl, stable);
    xact(0, 0, 4'd3, 2'b11, 16'h0000, 16'hFF12, 0, 4, "hl rd 11", we_cyc, sw4d, sw4u, any_ctl, stable);
    xact(0, 0, 4'd3, 2'b10, 16'h0000, 16'hFF00, 0, 4, "hl rd 10", we_cyc, sw4d, sw4u, any_ctl, stable);
    xact(0, 0, 4'd3, 2'b01, 16'h0000, 16'h0012, 0, 4, "hl rd 01", we_cyc, sw4d, sw4u, any_ctl, stable);

    xact(0, 0, 4'd9, 2'b11, 16'h0000, 16'h0000, 1, 2, "illegal reg", we_cyc, sw4d, sw4u, any_ctl, stable);
    check("illegal reg no ctl", any_ctl, 0);
    xact(0, 1, 4'd1, 2'b00, 16'h1234, 16'h0000, 1, 2, "illegal hilo", we_cyc, sw4d, sw4u, any_ctl, stable);
    check("illegal hilo no ctl", any_ctl, 0);
    xact(0, 0, 4'd1, 2'b11, 16'h0000, 16'hAB56, 0, 4, "bc rd after illegal", we_cyc, sw4d, sw4u, any_ctl, stable);

    xact(1, 1, 4'd4, 2'b11, 16'h1234, 16'h0000, 0, 7, "sp wr s4", we_cyc, sw4d, sw4u, any_ctl, stable);
    check("sp wr s4 we cycles", we_cyc, 1);
    check("sp wr s4 selects stable", stable, 5);
    check("sp wr s4 use_sp model", gp_regs[4], 16'h1234);
    xact(1, 0, 4'd4, 2'b11, 16'h0000, 16'h1234, 0, 7, "sp rd s4", we_cyc, sw4d, sw4u, any_ctl, stable);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_access_master.md
Name: reg_access_master

Overview:
Initiator for the register control/register file pair. It takes single-register read or write requests over a valid/ready handshake and sequences the control strobes and select lines that reg_control/reg_file expect. It drives or samples the data-side 16-bit bus and returns read data. It sits between debug/microcode-test logic and the register block, replacing hand-driven control sequences.

Parameters:
SETTLE_CYCLES, 1, cycles that selects, bus and in/out enables are held stable before the write strobe or read sample (1..15)

Ports:
clk  input  1  system clock, all state on rising edge
nreset  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_write  input  1  1=write, 0=read
req_reg  input  4  0 AF, 1 BC, 2 DE, 3 HL, 4 SP, 5 WZ, 6 PC, 7 IR, 8-15 illegal
req_hilo  input  2  byte lanes: [1]=high byte, [0]=low byte
req_wdata  input  16  write data
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  16  read data; unselected lanes and writes return 0
rsp_err  output  1  qualifies rsp_valid; illegal reg or hilo==00
ctl_reg_gp_sel  output  2  GP register select
ctl_reg_gp_hilo  output  2  GP lane select
ctl_reg_gp_we  output  1  GP write strobe
ctl_reg_use_sp  output  1  SP instead of AF/HL slot
ctl_reg_sys_hilo  output  2  system register lane select
ctl_reg_sys_we_hi  output  1  system high-byte write strobe
ctl_reg_sys_we_lo  output  1  system low-byte write strobe
ctl_reg_sel_wz, ctl_reg_sel_pc, ctl_reg_sel_ir  output  1 each  system register selects
ctl_reg_in_hi, ctl_reg_in_lo  output  1 each  bus-to-register gates
ctl_reg_out_hi, ctl_reg_out_lo  output  1 each  register-to-bus gates
ctl_sw_4d, ctl_sw_4u  output  1 each  bus switch #4 downstream/upstream gates
db_ds_out  output  16  data-side bus drive value {hi,lo}
db_ds_oe  output  1  enable for db_ds_out (external tristate)
db_ds_in  input  16  data-side bus sampled value {hi,lo}

Behaviour:
- Reset (async, nreset=0): FSM=IDLE. All ctl_* outputs, db_ds_oe, rsp_valid, rsp_err = 0. db_ds_out, rsp_rdata = 0. Settle counter = 0. Asserting nreset mid-operation aborts the transfer with no response. Strobes drop immediately.
- States: IDLE, CHECK, SETUP, ACT, DONE. req_ready = (state==IDLE).
- IDLE: on req_valid&&req_ready, latch req_* and go to CHECK.
- CHECK (1 cycle): if req_reg>7 or req_hilo==00, go to DONE with rsp_err set; no ctl/bus activity. Otherwise load counter = SETTLE_CYCLES and go to SETUP.
- SETUP: drive the selects and decrement the counter. Move to ACT when the counter reaches 1.
  - GP regs (0-3): gp_sel = reg[1:0], gp_hilo = hilo. SP uses gp_sel=11 with use_sp=1.
  - Sys regs: sys_hilo = hilo, plus the matching sel_wz/sel_pc/sel_ir.
- Write path (SETUP and ACT): in_hi=hilo[1], in_lo=hilo[0], db_ds_oe=1, db_ds_out = wdata with unselected lane 0. Sys writes also set ctl_sw_4d=1.
- Read path (SETUP and ACT): out_hi=hilo[1], out_lo=hilo[0], db_ds_oe=0. ctl_sw_4u=1 for PC/IR reads, 0 for WZ and GP reads.
- ACT (1 cycle), selects held:
  - Write: assert gp_we (GP/SP) or sys_we_hi=hilo[1] and sys_we_lo=hilo[0] (sys).
  - Read: capture db_ds_in lanes into rsp_rdata at the end of the cycle, with unselected lanes forced to 0.
- DONE (1 cycle): all ctl_*/oe deasserted, rsp_valid=1, then IDLE. rsp_rdata holds until the next accept. rsp_err=0 except on illegal requests.
- Latency: accept edge k → rsp_valid high in cycle k+SETTLE_CYCLES+3. Illegal requests respond at k+2.
- Write strobes never coincide with a selects change. Selects change only on IDLE→SETUP and ACT→DONE.
- No response backpressure. req_valid in non-IDLE states is ignored.
- Back-to-back requests: next accept in the cycle after DONE.

Test Plan:
- Reset: nreset=0 mid-SETUP of a PC write → all strobes/oe 0 at once, req_ready=1 after release, no rsp_valid.
- Write AF=AA55, BC=AB56, DE=AC57, HL=AD58 (hilo=11), then read each → rsp_rdata matches; gp_we pulses exactly 1 cycle per write; latency = SETTLE_CYCLES+3.
- Write WZ=8141, PC=8242, IR=8343, then read back → values match; ctl_sw_4d=1 only during sys writes; ctl_sw_4u=1 only on PC/IR reads.
- Byte lanes: write HL=FFFF, then HL hilo=01 with 0012 → read 11 gives FF12; read hilo=10 returns FF00.
- Illegal: req_reg=9 or hilo=00 → rsp_valid with rsp_err=1 two cycles after accept; no ctl_* toggles.
- SETTLE_CYCLES=4: SP write 1234 then read → selects stable 5 cycles before the strobe; rsp at k+7; data 1234.
